grey_sweep_ctrl: RTL and testbench
==================================

Name: grey_sweep_ctrl

Overview:
Sequencer that drives an n-bit binary-to-Gray encoder through a programmed run of consecutive codes. It accepts a start command with a first code, code count and direction, then emits one binary/Gray pair per cycle. It supports hold and abort, and signals completion. It sits between a test or control master and the Gray encoding datapath. It owns the encoder enable and produces registered Gray output for downstream logic.

Parameters:
n, 3, code width in bits (n >= 2)

Ports:
i_clk  input  1  system clock, rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  start request; sampled only in IDLE
i_first  input  n  first binary code of the run; captured on accepted start
i_count  input  n+1  number of codes to emit; captured on accepted start
i_dir  input  1  0 = increment, 1 = decrement; captured on accepted start
i_hold  input  1  pause emission while high (RUN only)
i_stop  input  1  abort current run
o_en  output  1  encoder enable; high in RUN and HOLD
o_bin  output  n  current binary code
o_grey  output  n  registered Gray code of o_bin (o_bin ^ (o_bin >> 1))
o_valid  output  1  o_bin/o_grey carry a new code this cycle
o_busy  output  1  high in any state other than IDLE
o_done  output  1  one-cycle pulse after the last code of a completed run

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: state = IDLE; all outputs = 0; internal remaining count = 0; captured direction = 0.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- IDLE:
  - i_start=1 and effective count > 0: capture i_first into o_bin, capture i_dir, set remaining = effective count, go to RUN.
  - i_start=1 and i_count = 0: go directly to DONE; no code is emitted.
  - i_stop and i_hold are ignored in IDLE.
- Effective count = min(i_count, 2**n). A run never exceeds one full cycle of codes.
- RUN, per cycle:
  - o_valid = 1, o_grey = gray(o_bin), o_en = 1.
  - Advance o_bin by +1 or -1 modulo 2**n.
  - Decrement remaining.
  - When remaining reaches 0 after an emission, go to DONE.
- Latency: the first code appears with o_valid=1 in the cycle after start is accepted. One code per cycle follows, with no gaps unless held.
- Wrap-around: up from 2**n-1 goes to 0; down from 0 goes to 2**n-1. The Gray output still changes by exactly one bit across the wrap.
- HOLD:
  - Entered from RUN when i_hold=1; the code that would be emitted is not emitted.
  - o_valid = 0. o_bin, o_grey and remaining are frozen. o_en stays 1.
  - Return to RUN the cycle after i_hold falls; emission resumes with the frozen o_bin.
- i_stop in RUN or HOLD:
  - Next state IDLE; o_valid = 0, o_en = 0, o_busy = 0; o_bin and o_grey hold their last values.
  - No o_done pulse.
  - i_stop has priority over i_hold and over normal completion.
- DONE: o_done = 1 for exactly one cycle, o_busy = 1, o_valid = 0, o_en = 0. Next state IDLE. i_start in DONE is ignored.
- i_start while busy is ignored; captured parameters are not disturbed.
- Reset mid-run: outputs return to reset values immediately (asynchronous). The run is lost and no o_done is issued.
- Emitted codes in one run: exactly the effective count. Consecutive valid o_grey values differ in exactly one bit.

Test Plan:
- n=3, start with first=0, count=8, dir=0 -> o_valid for 8 consecutive cycles. o_bin 0..7; o_grey 000,001,011,010,110,111,101,100. o_done pulses one cycle later, then IDLE.
- first=6, count=4, dir=0 -> o_bin 6,7,0,1; o_grey 101,100,000,001. Wrap verified; o_done follows.
- first=1, count=3, dir=1 -> o_bin 1,0,7; o_grey 001,000,100.
- first=2, count=5, dir=0, i_hold high 2 cycles after the second code -> o_valid low for 2 cycles with o_bin frozen at 4. Resumes with 4,5,6; the total of 5 codes is preserved.
- first=0, count=8, i_stop asserted after 3 codes -> IDLE next cycle, no o_done, o_busy=0. A new start is accepted the following cycle.
- count=0 -> o_done pulse 1 cycle after start, no o_valid. count=15 -> exactly 8 codes emitted. i_start during RUN is ignored. i_rst_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/grey_sweep_ctrl.sv
// rtl/grey_sweep_ctrl.sv - sequencer sweeping a binary-to-Gray encoder through a run of codes
//
// Purpose: on an accepted start, emits min(i_count, 2**n) consecutive binary
// codes (up or down, wrapping modulo 2**n) together with their Gray encoding,
// one per cycle, with hold, abort and a completion pulse. All outputs are
// registered.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  start request, honoured only in IDLE
//   i_first  first binary code of the run
//   i_count  number of codes to emit (n+1 bits, clamped to 2**n)
//   i_dir    0 = increment, 1 = decrement
//   i_hold   pause emission while high
//   i_stop   abort the current run (no done pulse)
//   o_en     encoder enable, high in RUN and HOLD
//   o_bin    current binary code
//   o_grey   Gray code of o_bin
//   o_valid  o_bin/o_grey carry a new code this cycle
//   o_busy   high in any state other than IDLE
//   o_done   one-cycle pulse after the last code of a completed run
module grey_sweep_ctrl #(
  parameter int n = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [n-1:0] i_first,
  input  logic [n:0]   i_count,
  input  logic         i_dir,
  input  logic         i_hold,
  input  logic         i_stop,
  output logic         o_en,
  output logic [n-1:0] o_bin,
  output logic [n-1:0] o_grey,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [n:0]   FULL = {1'b1, {n{1'b0}}};
  localparam logic [n-1:0] ONE  = {{(n-1){1'b0}}, 1'b1};

  logic [1:0]   state;
  // Codes still to be shown after the one currently on o_bin (or, in HOLD,
  // including the frozen code waiting on o_bin).
  logic [n:0]   remaining;
  logic         dir;
  logic [n:0]   eff_count;
  logic [n-1:0] next_bin;

  function automatic logic [n-1:0] gray(input logic [n-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    eff_count = (i_count > FULL) ? FULL : i_count;
    next_bin  = dir ? (o_bin - ONE) : (o_bin + ONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      dir       <= 1'b0;
      o_en      <= 1'b0;
      o_bin     <= '0;
      o_grey    <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            if (i_count == '0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              // The first code is presented straight away, so it already
              // counts as emitted.
              state     <= S_RUN;
              o_bin     <= i_first;
              o_grey    <= gray(i_first);
              dir       <= i_dir;
              remaining <= eff_count - 1'b1;
              o_valid   <= 1'b1;
              o_en      <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_stop) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
            o_en    <= 1'b0;
            o_busy  <= 1'b0;
          end else if (remaining == '0) begin
            state   <= S_DONE;
            o_valid <= 1'b0;
            o_en    <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            // The next code is loaded either way; under hold it waits on
            // o_bin with o_valid low and is emitted on resume.
            o_bin  <= next_bin;
            o_grey <= gray(next_bin);
            if (i_hold) begin
              state   <= S_HOLD;
              o_valid <= 1'b0;
            end else begin
              o_valid   <= 1'b1;
              remaining <= remaining - 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (i_stop) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
            o_en    <= 1'b0;
            o_busy  <= 1'b0;
          end else if (!i_hold) begin
            state     <= S_RUN;
            o_valid   <= 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
          o_en    <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grey_sweep_ctrl.sv
// tb/tb_grey_sweep_ctrl.sv - directed self-checking bench for grey_sweep_ctrl
module tb_grey_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] first;
  logic [3:0] count;
  logic       dir;
  logic       hold;
  logic       stop;
  logic       en;
  logic [2:0] bin;
  logic [2:0] grey;
  logic       valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  grey_sweep_ctrl #(.n(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_first (first),
    .i_count (count),
    .i_dir   (dir),
    .i_hold  (hold),
    .i_stop  (stop),
    .o_en    (en),
    .o_bin   (bin),
    .o_grey  (grey),
    .o_valid (valid),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {valid,en,busy,done,bin,grey} against the expected values.
  task automatic chk(input string tag, input logic v, input logic e, input logic b,
                     input logic d, input logic [2:0] eb, input logic [2:0] eg);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {valid, en, busy, done, bin, grey};
    exp = {v, e, b, d, eb, eg};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed v/e/b/d/bin/grey=%b required %b", tag, obs, exp);
    end
  endtask

  // Checks a valid code in RUN, then advances one cycle.
  task automatic code(input string tag, input logic [2:0] eb, input logic [2:0] eg);
    chk(tag, 1'b1, 1'b1, 1'b1, 1'b0, eb, eg);
    step();
  endtask

  task automatic go(input logic [2:0] f, input logic [3:0] c, input logic d);
    first = f;
    count = c;
    dir   = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; first = '0; count = '0; dir = 1'b0;
    hold = 1'b0; stop = 1'b0;
    step();
    step();
    chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    // Full up-sweep 0..7
    go(3'd0, 4'd8, 1'b0);
    code("up0", 3'd0, 3'b000);
    code("up1", 3'd1, 3'b001);
    code("up2", 3'd2, 3'b011);
    code("up3", 3'd3, 3'b010);
    code("up4", 3'd4, 3'b110);
    code("up5", 3'd5, 3'b111);
    code("up6", 3'd6, 3'b101);
    code("up7", 3'd7, 3'b100);
    chk("up_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 3'b100);
    step();
    chk("up_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 3'b100);

    // Wrap upward; a start pulse mid-run must be ignored
    go(3'd6, 4'd4, 1'b0);
    code("wrap0", 3'd6, 3'b101);
    first = 3'd2; count = 4'd1; dir = 1'b1; start = 1'b1;
    code("wrap1", 3'd7, 3'b100);
    start = 1'b0;
    code("wrap2", 3'd0, 3'b000);
    code("wrap3", 3'd1, 3'b001);
    chk("wrap_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 3'b001);
    step();
    chk("wrap_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'b001);

    // Down-sweep across zero
    go(3'd1, 4'd3, 1'b1);
    code("dn0", 3'd1, 3'b001);
    code("dn1", 3'd0, 3'b000);
    code("dn2", 3'd7, 3'b100);
    chk("dn_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 3'b100);
    step();

    // Hold for two cycles after the second code
    go(3'd2, 4'd5, 1'b0);
    code("hd0", 3'd2, 3'b011);
    chk("hd1", 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'b010);
    hold = 1'b1;
    step();
    chk("hold_a", 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 3'b110);
    step();
    chk("hold_b", 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 3'b110);
    hold = 1'b0;
    step();
    code("hd2", 3'd4, 3'b110);
    code("hd3", 3'd5, 3'b111);
    code("hd4", 3'd6, 3'b101);
    chk("hd_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 3'b101);
    step();

    // Abort after three codes, then restart immediately
    go(3'd0, 4'd8, 1'b0);
    code("ab0", 3'd0, 3'b000);
    code("ab1", 3'd1, 3'b001);
    chk("ab2", 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 3'b011);
    stop = 1'b1; hold = 1'b1;
    step();
    stop = 1'b0; hold = 1'b0;
    chk("abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'b011);
    go(3'd5, 4'd1, 1'b0);
    code("restart", 3'd5, 3'b111);
    chk("restart_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 3'b111);
    step();

    // Zero count: done without any code
    go(3'd3, 4'd0, 1'b0);
    chk("zero_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 3'b111);
    step();
    chk("zero_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'b111);

    // Count above 2**n clamps to 8 codes
    go(3'd3, 4'd15, 1'b0);
    code("cl0", 3'd3, 3'b010);
    code("cl1", 3'd4, 3'b110);
    code("cl2", 3'd5, 3'b111);
    code("cl3", 3'd6, 3'b101);
    code("cl4", 3'd7, 3'b100);
    code("cl5", 3'd0, 3'b000);
    code("cl6", 3'd1, 3'b001);
    code("cl7", 3'd2, 3'b011);
    chk("clamp_done", 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 3'b011);
    step();

    // Asynchronous reset mid-run
    go(3'd4, 4'd8, 1'b0);
    code("rs0", 3'd4, 3'b110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
